an_sec_serial_decoder: RTL and testbench
========================================

# an_sec_serial_decoder

Parametrised, sequential single-error-correcting decoder for AN (product) arithmetic codes. It accepts an N-bit codeword through a valid/ready handshake and reduces it modulo A serially. When the remainder is nonzero, it searches positions 1..N for an error of ±2^(k-1) by generating 2^(k-1) mod A on the fly, so no remainder lookup table is needed. It returns the corrected codeword, a signed error location and status flags, and sits between operand storage and the arithmetic datapath.

## Interface
- N, 68: codeword width in bits (positions 1..N).
- A, 50861: code constant; odd, 1 < A < 2^RW.
- RW, 16: remainder/power register width; 2^RW > A, and 2A must fit in RW+1 bits.
- LW, 8: width of signed location output; N ≤ 2^(LW-1)-1.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword offered.
- in_ready  output  1  high only in IDLE.
- in_cw  input  N  received codeword.
- out_valid  output  1  result held, high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_cw  output  N  corrected codeword (raw input if no error or uncorrectable).
- out_loc  output  LW  signed location: +k for error +2^(k-1), -k for error -2^(k-1), 0 otherwise.
- err_det  output  1  remainder was nonzero.
- err_uncorr  output  1  remainder nonzero and no position matched.

## Operation
- States: IDLE, REM, CHECK, SEARCH, CORR, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_cw, clear rem, bit index=N-1, go REM.
- REM: one bit per cycle, MSB first: t=2*rem+bit; rem = (t≥A) ? t-A : t. Single conditional subtract suffices since t<2A. After bit 0, go CHECK.
- CHECK: rem==0 → DONE with err_det=0, out_loc=0, out_cw=captured. Else err_det=1, p=1, k=1, go SEARCH.
- SEARCH, cycle k: p==rem → sign +, go CORR. Else (A-p)==rem → sign -, go CORR. Else if k==N → err_uncorr=1, out_loc=0, out_cw=captured, go DONE. Else p=(2p≥A)?2p-A:2p, k=k+1.
- A-p is never 0 (p nonzero, p<A). For A > 2^(N) aliasing is impossible; if positive and negative both match (cannot for odd A>2), + wins.
- CORR: sign + → out_cw = cw - 2^(k-1); sign - → out_cw = cw + 2^(k-1). Both are modulo 2^N (wrap, no carry out). out_loc = ±k sign-extended to LW. Go DONE.
- DONE: outputs stable while out_valid & !out_ready. On out_ready → IDLE.
- Reset (any time, including mid-REM/SEARCH): state IDLE, in_ready=1 after release, out_valid=0, out_cw=0, out_loc=0, err_det=0, err_uncorr=0, internal rem/p/k cleared. A partial result is discarded, never emitted.

## Timing
- Accept edge E0 (in_valid&in_ready sampled). REM updates on edges E0+1..E0+N; CHECK resolves at E0+N+1.
- Zero remainder: out_valid high after edge E0+N+1.
- Match at position k: compare at edge E0+N+1+k, CORR at E0+N+k+2; out_valid high after E0+N+k+2.
- No match: out_valid high after E0+2N+1.
- Handshake completes at edge where out_valid&out_ready; in_ready high from that edge. No back-to-back overlap; throughput one codeword per decode.
- in_cw is sampled only at E0; changes later are ignored.
- Outputs are registered; there is no combinational path from inputs to outputs except in_ready (state decode).

## Test plan
- Defaults, in_cw = 50861*12345 = 627879045 → rem 0, err_det=0, out_loc=0, out_cw=627879045, out_valid after E0+69.
- in_cw = 627879045+2^23 = 636267653 → rem 47404, out_loc=+24, out_cw=627879045, out_valid after E0+94.
- in_cw = 627879044 (error -2^0) → rem 50860, out_loc=-1, out_cw=627879045, out_valid after E0+71.
- in_cw = 627879048 (double error +1,+2) → rem 3, err_det=1, err_uncorr=1, out_loc=0, out_cw=627879048, out_valid after E0+137.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → all outputs unchanged, in_ready=0; accept on cycle 11 → in_ready=1 next cycle.
- Reset pulse at E0+80 of the +24 case → outputs zero immediately, no out_valid. A new clean codeword decodes normally with latency E0+69.

Source files
------------

// File: rtl/an_sec_serial_decoder.sv
// ============================================================================
// an_sec_serial_decoder
//
// Sequential single-error-correcting decoder for AN (product) arithmetic
// codes. A received N-bit codeword is reduced modulo A one bit per cycle.
// If the remainder is nonzero, the decoder walks positions k = 1..N. At each
// step it regenerates 2^(k-1) mod A by doubling, so no syndrome table is
// needed. A match against +2^(k-1) or -2^(k-1) is then undone on the
// captured codeword.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    codeword offered
//   in_ready    decoder idle and able to accept (state decode only)
//   in_cw       received codeword, sampled only on the accept edge
//   out_valid   result held (DONE)
//   out_ready   consumer accepts the held result
//   out_cw      corrected codeword, or the raw codeword if clean/uncorrectable
//   out_loc     signed error location: +k for +2^(k-1), -k for -2^(k-1), else 0
//   err_det     remainder was nonzero
//   err_uncorr  remainder nonzero and no single-bit-weight error matched
// ============================================================================
module an_sec_serial_decoder #(
    parameter int N  = 68,
    parameter int A  = 50861,
    parameter int RW = 16,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_cw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_cw,
    output logic [LW-1:0] out_loc,
    output logic          err_det,
    output logic          err_uncorr
);

    // Bit index counts N-1 down to 0. The position counter must be able to
    // hold N itself.
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(N + 1);

    // The code constant in the two widths the datapath needs. Sums before
    // the conditional subtract are one bit wider than the remainder.
    localparam logic [RW:0]   A_X = (RW + 1)'(A);
    localparam logic [RW-1:0] A_R = RW'(A);

    localparam logic [KW-1:0] K_LAST = KW'(N);
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REM    = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_SEARCH = 3'd3;
    localparam logic [2:0] S_CORR   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;

    logic [N-1:0]  cw_reg;      // codeword captured at accept
    logic [RW-1:0] rem_reg;     // running remainder mod A
    logic [IW-1:0] idx_reg;     // next codeword bit fed into the remainder
    logic [RW-1:0] p_reg;       // 2^(k-1) mod A for the current position
    logic [KW-1:0] k_reg;       // current search position, 1..N
    logic [N-1:0]  w_reg;       // 2^(k-1) as a codeword-wide one-hot weight
    logic          neg_reg;     // matched error was -2^(k-1)

    logic [N-1:0]  out_cw_reg;
    logic [LW-1:0] out_loc_reg;
    logic          err_det_reg;
    logic          err_uncorr_reg;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [RW:0]   rem_sum;
    logic [RW-1:0] rem_step;
    logic [RW:0]   p_dbl;
    logic [RW-1:0] p_step;
    logic [RW-1:0] p_neg;
    logic          hit_pos;
    logic          hit_neg;
    logic          k_last;
    logic [LW-1:0] loc_mag;
    logic [LW-1:0] loc_signed;
    logic [N-1:0]  cw_fixed;

    always_comb begin
        // rem < A, so 2*rem + bit < 2A. One conditional subtract brings the
        // sum back into [0, A).
        rem_sum  = {rem_reg, cw_reg[idx_reg]};
        rem_step = RW'(rem_sum);
        if (rem_sum >= A_X) begin
            rem_step = RW'(rem_sum - A_X);
        end

        // Same argument for doubling the power of two.
        p_dbl  = {p_reg, 1'b0};
        p_step = RW'(p_dbl);
        if (p_dbl >= A_X) begin
            p_step = RW'(p_dbl - A_X);
        end

        // -2^(k-1) mod A. p is never 0, so this never equals A.
        p_neg   = A_R - p_reg;
        hit_pos = (p_reg == rem_reg);
        hit_neg = (p_neg == rem_reg);
        k_last  = (k_reg == K_LAST);

        // KW < LW, so the location magnitude zero-extends into a
        // positive signed value.
        loc_mag    = {{(LW - KW){1'b0}}, k_reg};
        loc_signed = neg_reg ? (~loc_mag + 1'b1) : loc_mag;

        // Undo the error. Both directions wrap modulo 2^N.
        cw_fixed = neg_reg ? (cw_reg + w_reg) : (cw_reg - w_reg);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_REM;
                end
            end
            S_REM: begin
                if (idx_reg == '0) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = (rem_reg == '0) ? S_DONE : S_SEARCH;
            end
            S_SEARCH: begin
                if (hit_pos || hit_neg) begin
                    state_next = S_CORR;
                end else if (k_last) begin
                    state_next = S_DONE;
                end
            end
            S_CORR: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cw_reg         <= '0;
            rem_reg        <= '0;
            idx_reg        <= '0;
            p_reg          <= '0;
            k_reg          <= '0;
            w_reg          <= '0;
            neg_reg        <= 1'b0;
            out_cw_reg     <= '0;
            out_loc_reg    <= '0;
            err_det_reg    <= 1'b0;
            err_uncorr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        cw_reg  <= in_cw;
                        rem_reg <= '0;
                        idx_reg <= IDX_TOP;
                    end
                end
                S_REM: begin
                    rem_reg <= rem_step;
                    if (idx_reg != '0) begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                S_CHECK: begin
                    err_uncorr_reg <= 1'b0;
                    if (rem_reg == '0) begin
                        err_det_reg <= 1'b0;
                        out_loc_reg <= '0;
                        out_cw_reg  <= cw_reg;
                    end else begin
                        err_det_reg <= 1'b1;
                        p_reg       <= RW'(1);
                        k_reg       <= KW'(1);
                        w_reg       <= N'(1);
                        neg_reg     <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    // The positive match is tested first, so it wins if both
                    // could ever match.
                    if (hit_pos) begin
                        neg_reg <= 1'b0;
                    end else if (hit_neg) begin
                        neg_reg <= 1'b1;
                    end else if (k_last) begin
                        err_uncorr_reg <= 1'b1;
                        out_loc_reg    <= '0;
                        out_cw_reg     <= cw_reg;
                    end else begin
                        p_reg <= p_step;
                        k_reg <= k_reg + 1'b1;
                        w_reg <= {w_reg[N-2:0], 1'b0};
                    end
                end
                S_CORR: begin
                    out_cw_reg  <= cw_fixed;
                    out_loc_reg <= loc_signed;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == S_IDLE);
    assign out_valid  = (state_reg == S_DONE);
    assign out_cw     = out_cw_reg;
    assign out_loc    = out_loc_reg;
    assign err_det    = err_det_reg;
    assign err_uncorr = err_uncorr_reg;

endmodule

// File: tb/tb_an_sec_serial_decoder.sv
// Scoreboard bench for an_sec_serial_decoder. The driver pushes one expected
// result per codeword. The monitor pops it on the first out_valid cycle and
// also checks that the outputs stay stable while the result is held.
module tb_an_sec_serial_decoder;

    localparam int N  = 68;
    localparam int A  = 50861;
    localparam int RW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_cw = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_cw;
    logic [LW-1:0] out_loc;
    logic          err_det;
    logic          err_uncorr;

    an_sec_serial_decoder #(.N(N), .A(A), .RW(RW), .LW(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cw     (out_cw),
        .out_loc    (out_loc),
        .err_det    (err_det),
        .err_uncorr (err_uncorr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]  cw;
        logic [LW-1:0] loc;
        logic          det;
        logic          uncorr;
        int            lat;
        int            e0;
        string         tag;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic          prev_valid = 1'b0;
    logic [N-1:0]  hold_cw;
    logic [LW-1:0] hold_loc;
    logic          hold_det;
    logic          hold_unc;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.tag, "_cw"},      out_cw, e.cw);
                    chk({e.tag, "_loc"},     out_loc, e.loc);
                    chk({e.tag, "_det"},     err_det, e.det);
                    chk({e.tag, "_uncorr"},  err_uncorr, e.uncorr);
                    chk({e.tag, "_latency"}, cyc - e.e0, e.lat);
                    chk({e.tag, "_in_ready_low"}, in_ready, 0);
                    $display("txn %s: cw=%0d loc=%0d det=%0d unc=%0d lat=%0d",
                             e.tag, out_cw, $signed(out_loc), err_det, err_uncorr, cyc - e.e0);
                end
                hold_cw  = out_cw;
                hold_loc = out_loc;
                hold_det = err_det;
                hold_unc = err_uncorr;
            end else if (out_valid && prev_valid) begin
                chk("hold_cw",  out_cw, hold_cw);
                chk("hold_loc", out_loc, hold_loc);
                chk("hold_det", err_det, hold_det);
                chk("hold_unc", err_uncorr, hold_unc);
                chk("hold_in_ready", in_ready, 0);
            end
            prev_valid = out_valid;
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic send(input logic [N-1:0] cw, input logic [N-1:0] ecw,
                        input logic [LW-1:0] eloc, input logic edet,
                        input logic eunc, input int lat, input string tag,
                        output int e0);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        in_cw    = cw;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);         // accept edge E0
        @(negedge clk);
        e0        = cyc;
        in_valid  = 1'b0;
        in_cw     = '1;         // must be ignored after E0
        e.cw = ecw; e.loc = eloc; e.det = edet; e.uncorr = eunc;
        e.lat = lat; e.e0 = e0; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || out_valid) chk({tag, "_drain_timeout"}, 0, 1);
    endtask

    localparam logic [N-1:0] CW_OK  = 68'd627879045;
    localparam logic [N-1:0] CW_P24 = 68'd636267653;
    localparam logic [N-1:0] CW_M1  = 68'd627879044;
    localparam logic [N-1:0] CW_DBL = 68'd627879048;
    localparam logic [LW-1:0] LOC_0   = 8'd0;
    localparam logic [LW-1:0] LOC_P24 = 8'd24;
    localparam logic [LW-1:0] LOC_M1  = 8'hFF;

    initial begin
        int e0;
        int n;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cw", out_cw, 0);
        chk("rst_out_loc", out_loc, 0);
        chk("rst_err_det", err_det, 0);
        chk("rst_err_uncorr", err_uncorr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Directed cases
        send(CW_OK,  CW_OK,  LOC_0,   1'b0, 1'b0, 69,  "clean", e0);  drain("clean");
        send(CW_P24, CW_OK,  LOC_P24, 1'b1, 1'b0, 94,  "plus24", e0); drain("plus24");
        send(CW_M1,  CW_OK,  LOC_M1,  1'b1, 1'b0, 71,  "minus1", e0); drain("minus1");
        send(CW_DBL, CW_DBL, LOC_0,   1'b1, 1'b1, 137, "double", e0); drain("double");

        // Backpressure: result held 10 cycles, accepted on the 11th
        out_ready = 1'b0;
        send(CW_M1, CW_OK, LOC_M1, 1'b1, 1'b0, 71, "bp", e0);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reached_done", out_valid, 1);
        repeat (10) @(negedge clk);
        chk("bp_still_valid", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_valid_dropped", out_valid, 0);
        drain("bp");

        // Reset mid-search discards the partial result
        send(CW_P24, CW_OK, LOC_P24, 1'b1, 1'b0, 94, "aborted", e0);
        n = 0;
        while (cyc < e0 + 80 && n < 200) begin
            @(negedge clk);
            n++;
        end
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_cw", out_cw, 0);
        chk("abort_out_loc", out_loc, 0);
        chk("abort_err_det", err_det, 0);
        chk("abort_err_uncorr", err_uncorr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) chk("abort_no_valid", out_valid, 0);
            n++;
        end
        send(CW_OK, CW_OK, LOC_0, 1'b0, 1'b0, 69, "post_reset", e0);
        drain("post_reset");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
